ir_cmd_dispatcher: RTL and testbench



---
 rtl/ir_pkg.sv | 13 +
 rtl/ir_cmd_fifo.sv | 57 +++++
 rtl/ir_cmd_dispatcher.sv | 116 +++++++++++
 tb/tb_ir_cmd_dispatcher.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR command dispatcher.
package ir_pkg;

    localparam int CMD_W = 8;
    localparam logic [CMD_W-1:0] POWER_CMD_DEF = 8'h80;

    typedef enum logic [1:0] {
        ST_STANDBY = 2'b00,
        ST_WAKE    = 2'b10,
        ST_ON      = 2'b01
    } pwr_state_t;

endpackage

// File: rtl/ir_cmd_fifo.sv
// Small synchronous FIFO for accepted IR commands with a single-cycle flush.
module ir_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    // A write into a full FIFO is allowed when the head leaves on the same edge.
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/ir_cmd_dispatcher.sv
// IR command dispatcher: repeat filter, power state machine, command FIFO and drop counter.
module ir_cmd_dispatcher
    import ir_pkg::*;
#(
    parameter int               DEPTH       = 4,
    parameter int               HOLDOFF_CYC = 16,
    parameter int               WAKE_CYC    = 4,
    parameter logic [CMD_W-1:0] POWER_CMD   = POWER_CMD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] ir_cmd,
    input  logic             ir_valid,
    output logic [CMD_W-1:0] out_cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pwr_en,
    output logic             led,
    output logic [7:0]       drop_cnt
);

    localparam int HW = $clog2(HOLDOFF_CYC + 1);
    localparam int WW = $clog2(WAKE_CYC + 1);

    pwr_state_t       state;
    pwr_state_t       state_nxt;
    logic [HW-1:0]    holdoff;
    logic [CMD_W-1:0] last_cmd;
    logic [WW-1:0]    wake_cnt;
    logic             accept;
    logic             is_power;
    logic             pop;
    logic             flush;
    logic             wr_req;
    logic             wr_en;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    assign accept   = ir_valid && !((holdoff != '0) && (ir_cmd == last_cmd));
    assign is_power = (ir_cmd == POWER_CMD);
    assign pop      = out_valid && out_ready;
    assign flush    = accept && is_power && (state != ST_STANDBY);
    assign wr_req   = accept && !is_power && (state != ST_STANDBY);
    assign wr_en    = wr_req && (!fifo_full || pop);
    assign drop     = (accept && !is_power && (state == ST_STANDBY))
                   || (wr_req && fifo_full && !pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STANDBY;
        end else begin
            state <= state_nxt;
        end
    end

    // WAKE lasts WAKE_CYC cycles: leave when the counter is on its last count.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STANDBY: if (accept && is_power) state_nxt = ST_WAKE;
            ST_WAKE: begin
                if (accept && is_power)      state_nxt = ST_STANDBY;
                else if (wake_cnt <= WW'(1)) state_nxt = ST_ON;
            end
            ST_ON:      if (accept && is_power) state_nxt = ST_STANDBY;
            default:    state_nxt = ST_STANDBY;
        endcase
    end

    always_comb begin
        led       = (state == ST_STANDBY);
        pwr_en    = (state != ST_STANDBY);
        out_valid = (state == ST_ON) && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            holdoff  <= '0;
            last_cmd <= '0;
            wake_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                holdoff  <= HW'(HOLDOFF_CYC);
                last_cmd <= ir_cmd;
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HW'(1);
            end
            if (state == ST_STANDBY && state_nxt == ST_WAKE) begin
                wake_cnt <= WW'(WAKE_CYC);
            end else if (state == ST_WAKE && wake_cnt != '0) begin
                wake_cnt <= wake_cnt - WW'(1);
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    ir_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (ir_cmd),
        .rd_en   (pop),
        .rd_data (out_cmd),
        .flush   (flush),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_ir_cmd_dispatcher.sv
// Directed plus randomized bench for ir_cmd_dispatcher against a queue-based power/FIFO model.
module tb_ir_cmd_dispatcher;

    localparam int M_SB = 0;
    localparam int M_WK = 1;
    localparam int M_ON = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir_cmd;
    logic       ir_valid;
    logic [7:0] out_cmd;
    logic       out_valid;
    logic       out_ready;
    logic       pwr_en;
    logic       led;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int         m_state;
    int         m_hold;
    int         m_wleft;
    int         m_drop;
    logic [7:0] m_last;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    ir_cmd_dispatcher dut (
        .clk       (clk),
        .rst       (rst),
        .ir_cmd    (ir_cmd),
        .ir_valid  (ir_valid),
        .out_cmd   (out_cmd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pwr_en    (pwr_en),
        .led       (led),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_SB;
        m_hold  = 0;
        m_wleft = 0;
        m_drop  = 0;
        m_last  = 8'h00;
        q.delete();
    endtask

    task automatic add_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // Drive one cycle: compare outputs before the edge, then advance the model.
    task automatic step(input logic r, input logic v, input logic [7:0] c, input logic rdy);
        bit exp_valid;
        bit acc;
        bit pw;
        bit popv;
        bit full;
        rst = r; ir_valid = v; ir_cmd = c; out_ready = rdy;
        #1;
        exp_valid = (m_state == M_ON) && (q.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) chk("out_cmd", 32'(out_cmd), 32'(q[0]));
        chk("led", 32'(led), 32'(m_state == M_SB));
        chk("pwr_en", 32'(pwr_en), 32'(m_state != M_SB));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            acc  = v && !(m_hold > 0 && c == m_last);
            pw   = (c == 8'h80);
            popv = exp_valid && rdy;
            if (acc) begin
                m_last = c;
                m_hold = 16;
            end else if (m_hold > 0) begin
                m_hold--;
            end
            case (m_state)
                M_SB: begin
                    if (acc && pw) begin
                        m_state = M_WK;
                        m_wleft = 4;
                    end else if (acc) begin
                        add_drop();
                    end
                end
                M_WK: begin
                    if (acc && pw) begin
                        m_state = M_SB;
                        q.delete();
                    end else begin
                        if (acc) begin
                            if (q.size() < 4) q.push_back(c);
                            else add_drop();
                        end
                        m_wleft--;
                        if (m_wleft == 0) m_state = M_ON;
                    end
                end
                default: begin
                    if (acc && pw) begin
                        m_state = M_SB;
                        q.delete();
                    end else begin
                        full = (q.size() == 4);
                        if (popv) void'(q.pop_front());
                        if (acc) begin
                            if (!full || popv) q.push_back(c);
                            else add_drop();
                        end
                    end
                end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; ir_valid = 1'b0; ir_cmd = 8'h00; out_ready = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_out_cmd", 32'(out_cmd), 32'h0);

        // Standby drop, then power up and first command latency.
        step(1'b0, 1'b1, 8'h1F, 1'b1);
        idle(5, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        idle(5, 1'b1);
        step(1'b0, 1'b1, 8'h12, 1'b1);
        idle(3, 1'b1);

        // Toggle bounce: second 0x80 inside the holdoff is ignored.
        step(1'b0, 1'b1, 8'h80, 1'b1);
        idle(4, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        idle(14, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        idle(6, 1'b0);

        // Overfill while stalled, then drain.
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 8'(k), 1'b0);
            idle(1, 1'b0);
        end
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Power off with entries pending flushes them.
        step(1'b0, 1'b1, 8'h21, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b1, 8'h23, 1'b0);
        step(1'b0, 1'b1, 8'h80, 1'b0);
        idle(17, 1'b0);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        idle(6, 1'b1);

        // Command buffered during WAKE, then reset mid-handshake.
        step(1'b0, 1'b1, 8'h80, 1'b0);
        idle(17, 1'b0);
        step(1'b0, 1'b1, 8'h80, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        idle(5, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b0);
        chk("rst_mid_cmd", 32'(out_cmd), 32'h0);
        idle(3, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       v;
            logic [7:0] c;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(1, 4));
            step(r, v, c, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
